// File: rtl/frame_receiver.sv
// Serial frame receiver: hunts AA 55 sync, collects a fixed-size payload,
// verifies an 8-bit additive checksum and publishes the payload atomically.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx_data         - received byte from the upstream UART
//   rx_valid        - one-cycle strobe qualifying rx_data
//   data            - last accepted payload, data[k] = k-th payload byte
//   frame_strobe    - one-cycle pulse when data is updated
//   cksum_err       - one-cycle pulse when a complete frame fails its checksum
//   link_up         - high while the last good frame is younger than STALE_CYCLES
module frame_receiver #(
  parameter int NUM_DATA_BYTES = 20,
  parameter int GAP_CYCLES     = 50000,
  parameter int STALE_CYCLES   = 50000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [NUM_DATA_BYTES-1:0][7:0] data,
  output logic                           frame_strobe,
  output logic                           cksum_err,
  output logic                           link_up
);

  localparam int IW = (NUM_DATA_BYTES > 1) ? $clog2(NUM_DATA_BYTES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(STALE_CYCLES + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DATA_BYTES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    PAYLOAD,
    CKSUM
  } state_t;

  state_t                           state;
  logic [IW-1:0]                    idx;
  logic [7:0]                       sum;
  logic [NUM_DATA_BYTES-1:0][7:0]   shadow;
  logic [GW-1:0]                    gap_cnt;
  logic [SW-1:0]                    stale_cnt;
  logic                             good;

  // A frame completes well this cycle; it must beat stale expiry.
  assign good = rx_valid && (state == CKSUM) && (rx_data == sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      idx          <= '0;
      sum          <= '0;
      shadow       <= '0;
      gap_cnt      <= '0;
      stale_cnt    <= '0;
      data         <= '0;
      frame_strobe <= 1'b0;
      cksum_err    <= 1'b0;
      link_up      <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      cksum_err    <= 1'b0;

      // A byte arriving on the timeout cycle is still taken.
      if (rx_valid) begin
        gap_cnt <= '0;
        unique case (state)
          HUNT: begin
            if (rx_data == 8'hAA) state <= SYNC;
          end
          SYNC: begin
            if (rx_data == 8'h55) begin
              state <= PAYLOAD;
              idx   <= '0;
              sum   <= '0;
            end else if (rx_data != 8'hAA) begin
              state <= HUNT;
            end
          end
          PAYLOAD: begin
            shadow[idx] <= rx_data;
            sum         <= sum + rx_data;
            if (idx == LAST_IDX) state <= CKSUM;
            else idx <= idx + 1'b1;
          end
          CKSUM: begin
            if (good) begin
              data         <= shadow;
              frame_strobe <= 1'b1;
            end else begin
              cksum_err <= 1'b1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT) begin
        if (gap_cnt == GAP_MAX) begin
          state   <= HUNT;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end

      if (good) begin
        stale_cnt <= '0;
        link_up   <= 1'b1;
      end else if (stale_cnt != STALE_MAX) begin
        stale_cnt <= stale_cnt + 1'b1;
        if (stale_cnt == STALE_MAX - 1'b1) begin
          data    <= '0;
          link_up <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Testbench for frame_receiver: table-driven frames plus gap,
// stale, coincidence and mid-frame reset sequences.
module tb_frame_receiver;

  localparam int N     = 20;
  localparam int GAP   = 100;
  localparam int STALE = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [N-1:0][7:0] data;
  logic              frame_strobe;
  logic              cksum_err;
  logic              link_up;

  frame_receiver #(
    .NUM_DATA_BYTES(N),
    .GAP_CYCLES    (GAP),
    .STALE_CYCLES  (STALE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .data        (data),
    .frame_strobe(frame_strobe),
    .cksum_err   (cksum_err),
    .link_up     (link_up)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (frame_strobe) n_strobe++;
    if (cksum_err) n_err++;
  end

  logic [N-1:0][7:0] exp_data;
  logic [N-1:0][7:0] frame_pl;

  typedef struct {
    bit         pre_en;
    logic [7:0] pre;
    logic [7:0] seed;
    logic [7:0] step;
    bit         ok;
    bit         exp_strobe;
    bit         exp_err;
    bit         exp_link;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int i, input bit pre_en,
                         input logic [7:0] pre, input logic [7:0] seed,
                         input logic [7:0] step, input bit ok,
                         input bit es, input bit ee, input bit el,
                         input string name);
    vecs[i].pre_en     = pre_en;
    vecs[i].pre        = pre;
    vecs[i].seed       = seed;
    vecs[i].step       = step;
    vecs[i].ok         = ok;
    vecs[i].exp_strobe = es;
    vecs[i].exp_err    = ee;
    vecs[i].exp_link   = el;
    vecs[i].name       = name;
  endtask

  task automatic chk1(input string name, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name,
                       input logic [N*8-1:0] act,
                       input logic [N*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic make_pl(input logic [7:0] seed,
                         input logic [7:0] step);
    for (int k = 0; k < N; k++)
      frame_pl[k] = seed + 8'(k) * step;
  endtask

  function automatic logic [7:0] pl_sum();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < N; k++) s = s + frame_pl[k];
    return s;
  endfunction

  task automatic send_pl(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send_byte(frame_pl[k]);
  endtask

  // Ends #1 after the edge that takes the checksum byte.
  task automatic send_frame(input bit pre_en, input logic [7:0] pre,
                            input bit ok);
    if (pre_en) send_byte(pre);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(0, N - 1);
    send_byte(ok ? pl_sum() : pl_sum() + 8'h01);
  endtask

  int s0;
  int e0;

  initial begin
    set_vec(0, 0, 8'h00, 8'h00, 8'h01, 1, 1, 0, 1, "basic");
    set_vec(1, 0, 8'h00, 8'h00, 8'h01, 0, 0, 1, 1, "bad_ck");
    set_vec(2, 1, 8'hAA, 8'h40, 8'h03, 1, 1, 0, 1, "aa_aa_55");
    set_vec(3, 1, 8'h12, 8'hA0, 8'h05, 1, 1, 0, 1, "stray_12");
    set_vec(4, 0, 8'h00, 8'h55, 8'h55, 1, 1, 0, 1, "sync_in_pl");
    set_vec(5, 0, 8'h00, 8'h21, 8'h09, 0, 0, 1, 1, "bad_ck2");

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_data = '0;
    idle(3);
    chk_d("rst/data", data, '0);
    chk1("rst/strobe", frame_strobe, 1'b0);
    chk1("rst/err", cksum_err, 1'b0);
    chk1("rst/link", link_up, 1'b0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      make_pl(vecs[i].seed, vecs[i].step);
      send_frame(vecs[i].pre_en, vecs[i].pre, vecs[i].ok);
      if (vecs[i].exp_strobe) exp_data = frame_pl;
      chk1({vecs[i].name, "/strobe"}, frame_strobe, vecs[i].exp_strobe);
      chk1({vecs[i].name, "/err"}, cksum_err, vecs[i].exp_err);
      chk1({vecs[i].name, "/link"}, link_up, vecs[i].exp_link);
      chk_d({vecs[i].name, "/data"}, data, exp_data);
      idle(1);
      chk1({vecs[i].name, "/strobe_off"}, frame_strobe, 1'b0);
      chk1({vecs[i].name, "/err_off"}, cksum_err, 1'b0);
    end

    // Pause of exactly GAP idle cycles mid-payload is tolerated.
    make_pl(8'h10, 8'h07);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(0, 9);
    idle(GAP);
    send_pl(10, N - 1);
    send_byte(pl_sum());
    exp_data = frame_pl;
    chk1("gap_ok/strobe", frame_strobe, 1'b1);
    chk_d("gap_ok/data", data, exp_data);
    idle(1);

    // One more idle cycle drops the partial frame silently.
    s0 = n_strobe;
    e0 = n_err;
    make_pl(8'h61, 8'h0D);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(0, 4);
    idle(GAP + 1);
    chk1("gap_to/no_strobe", n_strobe != s0, 1'b0);
    chk1("gap_to/no_err", n_err != e0, 1'b0);
    chk_d("gap_to/data", data, exp_data);
    make_pl(8'h07, 8'h13);
    send_frame(0, 8'h00, 1);
    exp_data = frame_pl;
    chk1("gap_next/strobe", frame_strobe, 1'b1);
    chk_d("gap_next/data", data, exp_data);

    // Stale expiry STALE edges after the last good frame.
    idle(STALE - 1);
    chk1("stale_pre/link", link_up, 1'b1);
    chk_d("stale_pre/data", data, exp_data);
    idle(1);
    exp_data = '0;
    chk1("stale/link", link_up, 1'b0);
    chk_d("stale/data", data, exp_data);
    idle(5);
    chk1("stale_hold/link", link_up, 1'b0);
    chk_d("stale_hold/data", data, exp_data);
    make_pl(8'hC3, 8'h02);
    send_frame(0, 8'h00, 1);
    exp_data = frame_pl;
    chk1("relink/strobe", frame_strobe, 1'b1);
    chk1("relink/link", link_up, 1'b1);
    chk_d("relink/data", data, exp_data);

    // Good frame finishing on the very expiry edge wins.
    idle(STALE - (N + 3));
    make_pl(8'h5A, 8'h0B);
    send_frame(0, 8'h00, 1);
    exp_data = frame_pl;
    chk1("coinc/strobe", frame_strobe, 1'b1);
    chk1("coinc/link", link_up, 1'b1);
    chk_d("coinc/data", data, exp_data);
    idle(1);
    chk1("coinc_next/link", link_up, 1'b1);
    chk_d("coinc_next/data", data, exp_data);

    // Reset arriving with payload byte 10.
    make_pl(8'h33, 8'h11);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(0, 9);
    rst = 1'b1;
    send_byte(frame_pl[10]);
    exp_data = '0;
    chk_d("midrst/data", data, exp_data);
    chk1("midrst/link", link_up, 1'b0);
    chk1("midrst/strobe", frame_strobe, 1'b0);
    chk1("midrst/err", cksum_err, 1'b0);
    idle(1);
    rst = 1'b0;
    s0 = n_strobe;
    e0 = n_err;
    send_pl(11, N - 1);
    send_byte(pl_sum());
    idle(1);
    chk1("midrst_tail/no_strobe", n_strobe != s0, 1'b0);
    chk1("midrst_tail/no_err", n_err != e0, 1'b0);
    chk_d("midrst_tail/data", data, exp_data);
    make_pl(8'h81, 8'h03);
    send_frame(0, 8'h00, 1);
    exp_data = frame_pl;
    chk1("after_rst/strobe", frame_strobe, 1'b1);
    chk1("after_rst/link", link_up, 1'b1);
    chk_d("after_rst/data", data, exp_data);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 Parameter NUM_DATA_BYTES, default 20: payload bytes per frame; equals the segment decoder's data array depth.
REQ-002 Parameter GAP_CYCLES, default 50000: maximum idle clk cycles between bytes inside one frame.
REQ-003 Parameter STALE_CYCLES, default 50000000: idle clk cycles without a good frame before the output is blanked.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte from the upstream UART.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid when high.
REQ-008 data  output  NUM_DATA_BYTES x 8  last accepted payload; byte k = k-th payload byte received; feeds the segment decoder.
REQ-009 frame_strobe  output  1  one-cycle pulse when data is updated.
REQ-010 cksum_err  output  1  one-cycle pulse when a complete frame fails its checksum.
REQ-011 link_up  output  1  high while the last good frame is younger than STALE_CYCLES.

Function
REQ-012 Frame format SHALL be: 0xAA, 0x55, NUM_DATA_BYTES payload bytes, 1 checksum byte.
REQ-013 Checksum SHALL be the 8-bit sum, mod 256, of the payload bytes only; sync bytes excluded.
REQ-014 The FSM SHALL have 4 states: HUNT, SYNC, PAYLOAD, CKSUM.
REQ-015 HUNT: on rx_valid with 0xAA -> SYNC; any other byte -> stay in HUNT.
REQ-016 SYNC: 0x55 -> PAYLOAD, with byte index and running sum cleared; 0xAA -> stay in SYNC; other -> HUNT.
REQ-017 PAYLOAD: each byte goes into a shadow buffer at the index; index increments; sum accumulates; after byte NUM_DATA_BYTES-1 -> CKSUM.
REQ-018 Payload bytes equal to 0xAA or 0x55 SHALL be treated as plain data; there is no resync inside PAYLOAD.
REQ-019 CKSUM, byte matching sum: the whole shadow buffer SHALL be copied to data in one cycle; frame_strobe pulses; -> HUNT.
REQ-020 CKSUM, mismatch: data SHALL stay unchanged; cksum_err pulses; -> HUNT.
REQ-021 data, frame_strobe and cksum_err SHALL update on the clk edge after the cycle in which the checksum byte has rx_valid high; latency is 1 cycle.
REQ-022 data SHALL never show a partial frame; it changes only atomically per REQ-019 or REQ-024.
REQ-023 Gap counter: cleared on every rx_valid; counts while in SYNC, PAYLOAD or CKSUM; on reaching GAP_CYCLES -> HUNT, partial frame discarded, no error pulse.
REQ-024 Stale counter: cleared on every good frame; otherwise saturates at STALE_CYCLES; on reaching STALE_CYCLES, data is set to all zero (decoder blanks) and link_up goes low.
REQ-025 link_up SHALL rise with the first frame_strobe after reset or after going stale.
REQ-026 If a good frame completes in the same cycle that the stale counter expires, the good frame SHALL win: data loaded, link_up stays high.
REQ-027 If the gap timeout and rx_valid coincide, rx_valid SHALL win and the byte is processed normally.
REQ-028 The counters SHALL be sized to hold STALE_CYCLES and GAP_CYCLES without wrap.

Reset
REQ-029 While rst is high, all outputs SHALL be set on the next edge to: data all 0, frame_strobe 0, cksum_err 0, link_up 0.
REQ-030 While rst is high, the FSM SHALL go to HUNT and the counters, index, sum and shadow buffer SHALL be cleared.
REQ-031 rst asserted mid-frame SHALL discard the partial frame; the next frame after release is received normally.

Verification
REQ-032 Send AA 55, payload 00..13 (hex), checksum BE -> one cycle later data[k]=k, frame_strobe one pulse, link_up=1.
REQ-033 Same frame with checksum BF -> cksum_err one pulse; data and link_up unchanged from the prior state.
REQ-034 Send AA AA 55 + valid frame -> frame accepted; send 12 AA 55 + valid frame -> accepted after the stray byte.
REQ-035 Stop mid-payload for GAP_CYCLES (set to 100) -> FSM back in HUNT, no pulses; next full frame is accepted.
REQ-036 STALE_CYCLES=1000, no frames after a good one -> after 1000 cycles data all 0 and link_up=0; a good frame landing exactly on expiry keeps link_up=1.
REQ-037 Assert rst at payload byte 10 -> outputs at reset values; a full frame after release is accepted with correct data.
